// File: rtl/mdio_phy_mgr.sv
// PHY management sequencer: PHY soft-reset/init, periodic link/speed/duplex polling, and one software
// register port, all sharing a single mdio_if master through a registered valid/done handshake.
// Status and sw_ready update one cycle after mdio_ready. sw_valid is held until sw_ready; it is
// served only in IDLE.
module mdio_phy_mgr #(
    parameter int          POLL_INTERVAL = 1_000_000,
    parameter int          RST_POLL_MAX  = 16,
    parameter logic [15:0] BMCR_INIT     = 16'h9140,
    parameter logic [4:0]  PHYSTAT_REG   = 5'd17
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mdio_valid,
    output logic        mdio_write,
    output logic [4:0]  mdio_addr,
    output logic [15:0] mdio_wdata,
    input  logic        mdio_ready,
    input  logic [15:0] mdio_rdata,
    input  logic        sw_valid,
    input  logic        sw_write,
    input  logic [4:0]  sw_addr,
    input  logic [15:0] sw_wdata,
    output logic        sw_ready,
    output logic [15:0] sw_rdata,
    output logic        init_done,
    output logic        init_error,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        link_change
);

    localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_POLL_MAX - 1);

    typedef enum logic [2:0] {
        S_INIT_WR, S_RST_RD, S_IDLE, S_POLL_BMSR, S_POLL_PSTAT, S_SW_ACC
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] timer_q, timer_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic        bmsr_link_q, bmsr_link_d;
    logic        sw_wr_q, sw_wr_d;
    logic [4:0]  sw_addr_q, sw_addr_d;
    logic [15:0] sw_wdata_q, sw_wdata_d;
    logic        sw_ready_q, sw_ready_d;
    logic [15:0] sw_rdata_q, sw_rdata_d;
    logic        init_done_q, init_done_d, init_error_q, init_error_d;
    logic        link_q, link_d, fd_q, fd_d;
    logic [1:0]  speed_q, speed_d;
    logic        stat_vld_q, stat_vld_d, link_chg_q, link_chg_d;
    logic        done, new_link;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT_WR;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            rst_cnt_q    <= '0;
            bmsr_link_q  <= 1'b0;
            sw_wr_q      <= 1'b0;
            sw_addr_q    <= '0;
            sw_wdata_q   <= '0;
            sw_ready_q   <= 1'b0;
            sw_rdata_q   <= '0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            link_q       <= 1'b0;
            speed_q      <= '0;
            fd_q         <= 1'b0;
            stat_vld_q   <= 1'b0;
            link_chg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            rst_cnt_q    <= rst_cnt_d;
            bmsr_link_q  <= bmsr_link_d;
            sw_wr_q      <= sw_wr_d;
            sw_addr_q    <= sw_addr_d;
            sw_wdata_q   <= sw_wdata_d;
            sw_ready_q   <= sw_ready_d;
            sw_rdata_q   <= sw_rdata_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            link_q       <= link_d;
            speed_q      <= speed_d;
            fd_q         <= fd_d;
            stat_vld_q   <= stat_vld_d;
            link_chg_q   <= link_chg_d;
        end
    end

    // Each access state launches one request when req_q is low and leaves on its done pulse;
    // dropping req_q on done guarantees the idle gap before the next launch.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        rst_cnt_d    = rst_cnt_q;
        bmsr_link_d  = bmsr_link_q;
        sw_wr_d      = sw_wr_q;
        sw_addr_d    = sw_addr_q;
        sw_wdata_d   = sw_wdata_q;
        sw_ready_d   = 1'b0;
        sw_rdata_d   = sw_rdata_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        link_d       = link_q;
        speed_d      = speed_q;
        fd_d         = fd_q;
        stat_vld_d   = 1'b0;
        link_chg_d   = 1'b0;
        done         = req_q && mdio_ready;
        new_link     = mdio_rdata[11] && bmsr_link_q && mdio_rdata[10];

        case (state_q)
            S_INIT_WR: begin
                if (!req_q) begin
                    req_d = 1'b1; wr_d = 1'b1; addr_d = 5'd0; wdata_d = BMCR_INIT;
                end else if (done) begin
                    req_d = 1'b0; state_d = S_RST_RD;
                end
            end
            S_RST_RD: begin
                if (!req_q) begin
                    req_d = 1'b1; wr_d = 1'b0; addr_d = 5'd0; wdata_d = '0;
                end else if (done) begin
                    req_d = 1'b0;
                    if (!mdio_rdata[15]) begin
                        init_done_d = 1'b1; state_d = S_IDLE; timer_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 16'd1;
                        if (rst_cnt_q == RST_LAST) begin
                            init_error_d = 1'b1; init_done_d = 1'b1;
                            state_d = S_IDLE; timer_d = '0;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (timer_q == POLL_LAST) begin
                    state_d = S_POLL_BMSR;
                end else if (sw_valid) begin
                    state_d = S_SW_ACC;
                    sw_wr_d = sw_write; sw_addr_d = sw_addr; sw_wdata_d = sw_wdata;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_POLL_BMSR: begin
                if (!req_q) begin
                    req_d = 1'b1; wr_d = 1'b0; addr_d = 5'd1; wdata_d = '0;
                end else if (done) begin
                    req_d = 1'b0; bmsr_link_d = mdio_rdata[2]; state_d = S_POLL_PSTAT;
                end
            end
            S_POLL_PSTAT: begin
                if (!req_q) begin
                    req_d = 1'b1; wr_d = 1'b0; addr_d = PHYSTAT_REG; wdata_d = '0;
                end else if (done) begin
                    req_d = 1'b0;
                    if (mdio_rdata[11]) begin
                        speed_d = mdio_rdata[15:14];
                        fd_d    = mdio_rdata[13];
                    end
                    link_d     = new_link;
                    link_chg_d = (new_link != link_q);
                    stat_vld_d = 1'b1;
                    state_d    = S_IDLE;
                    timer_d    = '0;
                end
            end
            S_SW_ACC: begin
                if (!req_q) begin
                    req_d = 1'b1; wr_d = sw_wr_q; addr_d = sw_addr_q; wdata_d = sw_wdata_q;
                end else if (done) begin
                    req_d      = 1'b0;
                    sw_rdata_d = sw_wr_q ? 16'h0000 : mdio_rdata;
                    sw_ready_d = 1'b1;
                    state_d    = S_IDLE;
                    timer_d    = '0;
                end
            end
            default: state_d = S_INIT_WR;
        endcase
    end

    assign mdio_valid   = req_q;
    assign mdio_write   = wr_q;
    assign mdio_addr    = addr_q;
    assign mdio_wdata   = wdata_q;
    assign sw_ready     = sw_ready_q;
    assign sw_rdata     = sw_rdata_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign link_up      = link_q;
    assign speed        = speed_q;
    assign full_duplex  = fd_q;
    assign status_valid = stat_vld_q;
    assign link_change  = link_chg_q;

endmodule

// File: tb/tb_mdio_phy_mgr.sv
// Directed bench for mdio_phy_mgr with a behavioural PHY answering each request after three cycles.
module tb_mdio_phy_mgr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdio_valid, mdio_write, mdio_ready = 1'b0;
    logic [4:0]  mdio_addr;
    logic [15:0] mdio_wdata, mdio_rdata = 16'h0;
    logic        sw_valid = 1'b0, sw_write = 1'b0;
    logic [4:0]  sw_addr = 5'd0;
    logic [15:0] sw_wdata = 16'h0;
    logic        sw_ready, init_done, init_error, link_up, full_duplex, status_valid, link_change;
    logic [15:0] sw_rdata;
    logic [1:0]  speed;

    int tests = 0;
    int fails = 0;

    logic [15:0] bmsr_val = 16'h796D;
    logic [15:0] pstat_val = 16'hAC00;
    logic        bmcr_stuck = 1'b0;
    int          dly = 0;
    int          bmcr_rd = 0;
    logic        log_wr[$];
    logic [4:0]  log_addr[$];
    logic [15:0] log_wdata[$];

    mdio_phy_mgr #(.POLL_INTERVAL(200)) dut (
        .clk(clk), .reset(reset),
        .mdio_valid(mdio_valid), .mdio_write(mdio_write), .mdio_addr(mdio_addr),
        .mdio_wdata(mdio_wdata), .mdio_ready(mdio_ready), .mdio_rdata(mdio_rdata),
        .sw_valid(sw_valid), .sw_write(sw_write), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
        .sw_ready(sw_ready), .sw_rdata(sw_rdata),
        .init_done(init_done), .init_error(init_error), .link_up(link_up), .speed(speed),
        .full_duplex(full_duplex), .status_valid(status_valid), .link_change(link_change)
    );

    always #5 clk = ~clk;

    // PHY model: completed transactions are logged in order; BMCR[15] clears on the 2nd read unless stuck.
    always @(negedge clk) begin
        if (reset) bmcr_rd = 0;
        if (mdio_ready) begin
            mdio_ready = 1'b0;
        end else if (!mdio_valid) begin
            dly = 0;
        end else if (dly < 2) begin
            dly++;
        end else begin
            dly = 0;
            log_wr.push_back(mdio_write);
            log_addr.push_back(mdio_addr);
            log_wdata.push_back(mdio_wdata);
            if (mdio_write) mdio_rdata = 16'hBEEF;
            else begin
                case (mdio_addr)
                    5'd0: begin
                        bmcr_rd++;
                        mdio_rdata = (bmcr_stuck || bmcr_rd < 2) ? 16'h9140 : 16'h1140;
                    end
                    5'd1:    mdio_rdata = bmsr_val;
                    5'd2:    mdio_rdata = 16'h0141;
                    5'd17:   mdio_rdata = pstat_val;
                    default: mdio_rdata = 16'hDEAD;
                endcase
            end
            mdio_ready = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        int base;
        int rd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mdio_valid", mdio_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_init_error", init_error, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_speed", speed, 0);
        chk("rst_fd", full_duplex, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_sw_ready", sw_ready, 0);
        chk("rst_sw_rdata", sw_rdata, 0);

        // Init with BMCR[15] clearing on the 2nd read
        reset = 1'b0;
        @(negedge clk);
        chk("init_wr_valid", mdio_valid, 1);
        chk("init_wr_write", mdio_write, 1);
        chk("init_wr_addr", mdio_addr, 0);
        chk("init_wr_wdata", mdio_wdata, 16'h9140);
        n = 0;
        while (!init_done && n < 300) begin @(negedge clk); n++; end
        chk("init_done", init_done, 1);
        chk("init_error", init_error, 0);
        chk("init_log_size", log_wr.size(), 3);
        chk("init_log0_wr", log_wr[0], 1);
        chk("init_log0_wdata", log_wdata[0], 16'h9140);
        chk("init_log1_rd0", {log_wr[1], log_addr[1]}, 0);
        chk("init_log2_rd0", {log_wr[2], log_addr[2]}, 0);
        chk("init_bmcr_reads", bmcr_rd, 2);

        // First poll: link up, 1000M, full duplex
        base = log_wr.size();
        n = 0;
        while (!status_valid && n < 500) begin @(negedge clk); n++; end
        chk("poll1_status_valid", status_valid, 1);
        chk("poll1_link_up", link_up, 1);
        chk("poll1_speed", speed, 2'b10);
        chk("poll1_fd", full_duplex, 1);
        chk("poll1_link_change", link_change, 1);
        chk("poll1_order", {log_addr[base], log_addr[base+1]}, {5'd1, 5'd17});
        @(negedge clk);
        chk("poll1_sv_pulse", status_valid, 0);
        chk("poll1_lc_pulse", link_change, 0);

        // Second poll: latched-low link bit cleared
        bmsr_val = 16'h7969;
        n = 0;
        while (!status_valid && n < 500) begin @(negedge clk); n++; end
        chk("poll2_status_valid", status_valid, 1);
        chk("poll2_link_up", link_up, 0);
        chk("poll2_link_change", link_change, 1);
        chk("poll2_speed", speed, 2'b10);

        // Third poll: unresolved, previous speed/duplex kept, no link_change
        bmsr_val = 16'h796D;
        pstat_val = 16'h0400;
        @(negedge clk);
        n = 0;
        while (!status_valid && n < 500) begin @(negedge clk); n++; end
        chk("poll3_status_valid", status_valid, 1);
        chk("poll3_link_up", link_up, 0);
        chk("poll3_link_change", link_change, 0);
        chk("poll3_speed", speed, 2'b10);
        chk("poll3_fd", full_duplex, 1);

        // Software write: sw_rdata must be zero
        repeat (3) @(negedge clk);
        sw_valid = 1'b1; sw_write = 1'b1; sw_addr = 5'd4; sw_wdata = 16'h01E1;
        n = 0;
        while (!sw_ready && n < 100) begin @(negedge clk); n++; end
        sw_valid = 1'b0;
        chk("swwr_ready", sw_ready, 1);
        chk("swwr_rdata", sw_rdata, 0);
        chk("swwr_log", {log_wr[log_wr.size()-1], log_addr[log_addr.size()-1],
                         log_wdata[log_wdata.size()-1]}, {1'b1, 5'd4, 16'h01E1});
        @(negedge clk);

        // Software read of PHY ID
        sw_valid = 1'b1; sw_write = 1'b0; sw_addr = 5'd2; sw_wdata = 16'h0;
        n = 0;
        while (!sw_ready && n < 100) begin @(negedge clk); n++; end
        sw_valid = 1'b0;
        chk("swrd_ready", sw_ready, 1);
        chk("swrd_rdata", sw_rdata, 16'h0141);
        @(negedge clk);
        chk("swrd_pulse", sw_ready, 0);

        // Request raised exactly in the timer-expiry cycle: poll goes first
        repeat (198) @(negedge clk);
        base = log_wr.size();
        sw_valid = 1'b1; sw_addr = 5'd2;
        n = 0;
        while (!sw_ready && n < 200) begin @(negedge clk); n++; end
        sw_valid = 1'b0;
        chk("coll_sw_ready", sw_ready, 1);
        chk("coll_log_size", log_wr.size(), base + 3);
        chk("coll_order", {log_addr[base], log_addr[base+1], log_addr[base+2]},
            {5'd1, 5'd17, 5'd2});
        chk("coll_rdata", sw_rdata, 16'h0141);

        // PHY reset bit never clears
        reset = 1'b1;
        bmcr_stuck = 1'b1;
        @(negedge clk);
        chk("stuck_rst_init_done", init_done, 0);
        base = log_wr.size();
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 1000) begin @(negedge clk); n++; end
        chk("stuck_init_done", init_done, 1);
        chk("stuck_init_error", init_error, 1);
        chk("stuck_log_size", log_wr.size(), base + 17);
        chk("stuck_first_wr", log_wr[base], 1);
        rd0 = 0;
        for (int i = base + 1; i < log_wr.size(); i++)
            if (!log_wr[i] && log_addr[i] == 5'd0) rd0++;
        chk("stuck_bmcr_reads", rd0, 16);
        n = 0;
        while (!status_valid && n < 500) begin @(negedge clk); n++; end
        chk("stuck_polling", status_valid, 1);

        // Reset asserted while the init write is in flight
        bmcr_stuck = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_inflight", mdio_valid, 1);
        base = log_wr.size();
        reset = 1'b1;
        #1;
        chk("midrst_valid_drop", mdio_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_reissue_valid", mdio_valid, 1);
        chk("midrst_reissue_op", {mdio_write, mdio_addr, mdio_wdata}, {1'b1, 5'd0, 16'h9140});
        chk("midrst_aborted_not_logged", log_wr.size(), base);
        n = 0;
        while (!init_done && n < 300) begin @(negedge clk); n++; end
        chk("midrst_init_done", init_done, 1);
        chk("midrst_init_error", init_error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
